// File: rtl/lsa_pkg.sv
// Shared definitions for the list search/append initiator: FSM states, widths
// and the fixed memory locations of the routing lists it maintains.
package lsa_pkg;

  localparam int ADDR_W = 11;
  localparam int WORD_W = 16;
  localparam int IDX_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_COUNT,
    SCAN,
    APPEND,
    INC_COUNT,
    DONE
  } lsa_state_t;

  // Entry-0 byte address and count-word byte address of each standard list
  localparam logic [ADDR_W-1:0] KNOWN_SINKS_BASE  = 11'h008;
  localparam logic [ADDR_W-1:0] KNOWN_SINKS_COUNT = 11'h688;
  localparam logic [ADDR_W-1:0] BETTER_NBR_BASE   = 11'h668;
  localparam logic [ADDR_W-1:0] BETTER_NBR_COUNT  = 11'h68C;
  localparam logic [ADDR_W-1:0] SINK_IDS_BASE     = 11'h248;
  localparam logic [ADDR_W-1:0] SINK_IDS_COUNT    = 11'h68E;

endpackage

// File: rtl/list_search_append.sv
// Scans a word list in mem for a key and, on a miss with appending enabled,
// writes the key at the tail and bumps the stored count.
module list_search_append #(
  parameter int MAX_COUNT = 16,
  parameter int ADDR_W    = 11
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [lsa_pkg::WORD_W-1:0] key,
  input  logic [ADDR_W-1:0]         list_base,
  input  logic [ADDR_W-1:0]         count_addr,
  input  logic                      append_en,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic                      full,
  output logic [lsa_pkg::IDX_W-1:0] index,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_wr_en,
  output logic [lsa_pkg::WORD_W-1:0] mem_wdata,
  input  logic [lsa_pkg::WORD_W-1:0] mem_rdata
);

  import lsa_pkg::*;

  localparam logic [IDX_W-1:0] MAX_C = IDX_W'(MAX_COUNT);

  lsa_state_t        state, state_d;
  logic [WORD_W-1:0] key_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_addr_q;
  logic              append_q;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  cnt;

  logic              exhausted;
  logic              hit;
  logic              room;
  logic [ADDR_W-1:0] entry_addr;
  logic [ADDR_W-1:0] tail_addr;

  assign exhausted  = (i == cnt);
  assign hit        = (mem_rdata == key_q);
  assign room       = (cnt < MAX_C);
  assign entry_addr = base_q + (ADDR_W'(i) << 1);
  assign tail_addr  = base_q + (ADDR_W'(cnt) << 1);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_d     = state;
    mem_address = '0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        if (start) state_d = RD_COUNT;
      end
      RD_COUNT: begin
        mem_address = count_addr_q;
        state_d     = SCAN;
      end
      SCAN: begin
        if (exhausted) begin
          state_d = (append_q && room) ? APPEND : DONE;
        end else begin
          mem_address = entry_addr;
          if (hit) state_d = DONE;
        end
      end
      APPEND: begin
        mem_address = tail_addr;
        mem_wdata   = key_q;
        mem_wr_en   = 1'b1;
        state_d     = INC_COUNT;
      end
      INC_COUNT: begin
        mem_address = count_addr_q;
        mem_wdata   = WORD_W'(cnt) + WORD_W'(1);
        mem_wr_en   = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Result flags change only on the edge entering DONE, so they hold between pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q        <= '0;
      base_q       <= '0;
      count_addr_q <= '0;
      append_q     <= 1'b0;
      i            <= '0;
      cnt          <= '0;
      found        <= 1'b0;
      full         <= 1'b0;
      index        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q        <= key;
            base_q       <= list_base;
            count_addr_q <= count_addr;
            append_q     <= append_en;
            i            <= '0;
          end
        end
        RD_COUNT: begin
          cnt <= (mem_rdata > WORD_W'(MAX_COUNT)) ? MAX_C : mem_rdata[IDX_W-1:0];
        end
        SCAN: begin
          if (exhausted) begin
            if (!append_q) begin
              found <= 1'b0;
              full  <= 1'b0;
            end else if (!room) begin
              found <= 1'b0;
              full  <= 1'b1;
            end
          end else if (hit) begin
            found <= 1'b1;
            full  <= 1'b0;
            index <= i;
          end else begin
            i <= i + IDX_W'(1);
          end
        end
        INC_COUNT: begin
          found <= 1'b0;
          full  <= 1'b0;
          index <= cnt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_list_search_append.sv
// Directed bench for list_search_append against a small word-addressed memory
// model preloaded with the knownSinks, betterneighbors and sinkIDs lists.
module tb_list_search_append;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] key;
  logic [10:0] list_base;
  logic [10:0] count_addr;
  logic        append_en;
  logic        busy;
  logic        done;
  logic        found;
  logic        full;
  logic [5:0]  index;
  logic [10:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:1023];
  int          wr_count = 0;
  int          checks   = 0;
  int          failures = 0;
  int          dc;
  int          wr_before;

  list_search_append #(.MAX_COUNT(16), .ADDR_W(11)) dut (
    .clock(clock), .reset(reset), .start(start), .key(key),
    .list_base(list_base), .count_addr(count_addr), .append_en(append_en),
    .busy(busy), .done(done), .found(found), .full(full), .index(index),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_address[10:1]];

  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem[mem_address[10:1]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic pokeWord(input logic [10:0] addr, input logic [15:0] val);
    mem[addr[10:1]] <= val;
  endtask

  function automatic logic [15:0] peekWord(input logic [10:0] addr);
    return mem[addr[10:1]];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Launches one operation; returns the cycle of the done pulse (0 if none or reset)
  task automatic applyStimulus(input logic [15:0] k_key, input logic [10:0] base,
                               input logic [10:0] caddr, input logic app,
                               input int noise_cycles, input int reset_cycle,
                               output int done_cycle);
    bit stop_loop;
    @(negedge clock);
    start      = 1'b1;
    key        = k_key;
    list_base  = base;
    count_addr = caddr;
    append_en  = app;
    @(posedge clock);
    done_cycle = 0;
    stop_loop  = 1'b0;
    for (int k = 1; k <= 200 && !stop_loop; k++) begin
      @(negedge clock);
      if (k <= noise_cycles) begin
        start = 1'b1;
        key   = 16'h0002;
      end else begin
        start = 1'b0;
      end
      if (k == reset_cycle) begin
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        stop_loop = 1'b1;
      end else if (done) begin
        done_cycle = k;
        stop_loop  = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key = '0; list_base = '0; count_addr = '0; append_en = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] <= 16'h0000;
    repeat (3) @(posedge clock);
    pokeWord(11'h008, 16'd2);  pokeWord(11'h00A, 16'd5);  pokeWord(11'h00C, 16'd10);
    pokeWord(11'h00E, 16'd171); pokeWord(11'h010, 16'd205); pokeWord(11'h688, 16'd5);
    pokeWord(11'h68C, 16'd0);  pokeWord(11'h68E, 16'd0);
    for (int e = 0; e < 16; e++) pokeWord(11'h100 + 11'(2 * e), 16'(100 + e));
    pokeWord(11'h300, 16'd16);
    @(negedge clock);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_found", 32'(found), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_index", 32'(index), 32'd0);
    checkOutput("rst_addr", 32'(mem_address), 32'd0);
    checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;

    $display("[TB] hit key=10 in knownSinks");
    wr_before = wr_count;
    applyStimulus(16'd10, 11'h008, 11'h688, 1'b1, 0, 0, dc);
    checkOutput("hit_cycle", 32'(dc), 32'd5);
    checkOutput("hit_found", 32'(found), 32'd1);
    checkOutput("hit_index", 32'(index), 32'd2);
    checkOutput("hit_full", 32'(full), 32'd0);
    checkOutput("hit_writes", 32'(wr_count - wr_before), 32'd0);

    $display("[TB] append key=7 to knownSinks");
    wr_before = wr_count;
    applyStimulus(16'd7, 11'h008, 11'h688, 1'b1, 0, 0, dc);
    checkOutput("app_cycle", 32'(dc), 32'd10);
    checkOutput("app_found", 32'(found), 32'd0);
    checkOutput("app_index", 32'(index), 32'd5);
    checkOutput("app_tail", 32'(peekWord(11'h012)), 32'h0007);
    checkOutput("app_count", 32'(peekWord(11'h688)), 32'h0006);
    checkOutput("app_writes", 32'(wr_count - wr_before), 32'd2);

    $display("[TB] rerun key=7");
    applyStimulus(16'd7, 11'h008, 11'h688, 1'b1, 0, 0, dc);
    checkOutput("rerun_cycle", 32'(dc), 32'd8);
    checkOutput("rerun_found", 32'(found), 32'd1);
    checkOutput("rerun_index", 32'(index), 32'd5);

    $display("[TB] append to empty betterneighbors");
    wr_before = wr_count;
    applyStimulus(16'd3, 11'h668, 11'h68C, 1'b1, 0, 0, dc);
    checkOutput("empty_cycle", 32'(dc), 32'd5);
    checkOutput("empty_tail", 32'(peekWord(11'h668)), 32'h0003);
    checkOutput("empty_count", 32'(peekWord(11'h68C)), 32'h0001);
    checkOutput("empty_index", 32'(index), 32'd0);
    checkOutput("empty_writes", 32'(wr_count - wr_before), 32'd2);

    $display("[TB] empty sinkIDs without append");
    wr_before = wr_count;
    applyStimulus(16'd3, 11'h248, 11'h68E, 1'b0, 0, 0, dc);
    checkOutput("noapp_cycle", 32'(dc), 32'd3);
    checkOutput("noapp_found", 32'(found), 32'd0);
    checkOutput("noapp_full", 32'(full), 32'd0);
    checkOutput("noapp_writes", 32'(wr_count - wr_before), 32'd0);

    $display("[TB] full list, count=16");
    wr_before = wr_count;
    applyStimulus(16'd1, 11'h100, 11'h300, 1'b1, 0, 0, dc);
    checkOutput("full_cycle", 32'(dc), 32'd19);
    checkOutput("full_full", 32'(full), 32'd1);
    checkOutput("full_found", 32'(found), 32'd0);
    checkOutput("full_writes", 32'(wr_count - wr_before), 32'd0);

    $display("[TB] hit last slot of full list");
    applyStimulus(16'd115, 11'h100, 11'h300, 1'b1, 0, 0, dc);
    checkOutput("last_cycle", 32'(dc), 32'd18);
    checkOutput("last_found", 32'(found), 32'd1);
    checkOutput("last_index", 32'(index), 32'd15);
    checkOutput("last_full", 32'(full), 32'd0);

    $display("[TB] count=40 clamps to 16");
    @(negedge clock);
    pokeWord(11'h300, 16'd40);
    wr_before = wr_count;
    applyStimulus(16'd1, 11'h100, 11'h300, 1'b1, 0, 0, dc);
    checkOutput("clamp_cycle", 32'(dc), 32'd19);
    checkOutput("clamp_full", 32'(full), 32'd1);
    checkOutput("clamp_found", 32'(found), 32'd0);
    checkOutput("clamp_writes", 32'(wr_count - wr_before), 32'd0);

    $display("[TB] start pulses while busy are ignored");
    applyStimulus(16'd205, 11'h008, 11'h688, 1'b1, 3, 0, dc);
    checkOutput("noise_cycle", 32'(dc), 32'd7);
    checkOutput("noise_index", 32'(index), 32'd4);
    checkOutput("noise_found", 32'(found), 32'd1);
    @(negedge clock);
    checkOutput("noise_idle", 32'(busy), 32'd0);

    $display("[TB] reset during SCAN");
    wr_before = wr_count;
    applyStimulus(16'd171, 11'h008, 11'h688, 1'b1, 0, 2, dc);
    checkOutput("rscan_busy", 32'(busy), 32'd0);
    checkOutput("rscan_done", 32'(done), 32'd0);
    checkOutput("rscan_found", 32'(found), 32'd0);
    checkOutput("rscan_index", 32'(index), 32'd0);
    checkOutput("rscan_addr", 32'(mem_address), 32'd0);
    checkOutput("rscan_count", 32'(peekWord(11'h688)), 32'h0006);
    checkOutput("rscan_writes", 32'(wr_count - wr_before), 32'd0);

    $display("[TB] reset during APPEND");
    applyStimulus(16'd9, 11'h248, 11'h68E, 1'b1, 0, 3, dc);
    checkOutput("rapp_tail", 32'(peekWord(11'h248)), 32'h0009);
    checkOutput("rapp_count", 32'(peekWord(11'h68E)), 32'h0000);
    checkOutput("rapp_busy", 32'(busy), 32'd0);
    checkOutput("rapp_wr_en", 32'(mem_wr_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/list_search_append.md
# list_search_append

Memory-side initiator that drives the 16-bit, byte-addressed, big-endian word port of `mem`. It reads a list's count word, scans the list for a 16-bit key and, when the key is absent and appending is enabled, writes the key at the list tail and increments the count. It serves the routing FSMs that maintain knownSinks (0x008/0x688), betterneighbors (0x668/0x68C) and per-neighbour sinkIDs lists.

## Interface
Parameters:
- `MAX_COUNT`, 16: list capacity in words; `1..63`.
- `ADDR_W`, 11: memory byte-address width.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `key`  in  16  value to find; latched on accepted `start`.
- `list_base`  in  11  byte address of entry 0; latched on accepted `start`.
- `count_addr`  in  11  byte address of count word; latched on accepted `start`.
- `append_en`  in  1  append on miss; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  key present before this operation; valid with `done`, held until next `done`.
- `full`  out  1  miss with list at capacity, no write made; valid with `done`, held.
- `index`  out  6  hit index, or new tail index on append; valid with `done`, held.
- `mem_address`  out  11  to `mem.address`.
- `mem_wr_en`  out  1  to `mem.wr_en`.
- `mem_wdata`  out  16  to `mem.data_in`.
- `mem_rdata`  in  16  from `mem.data_out`; combinational, valid in the same cycle as `mem_address`.

## Operation
- States: IDLE, RD_COUNT, SCAN, APPEND, INC_COUNT, DONE.
- IDLE: `start`=1 latches inputs, clears `i`, and goes to RD_COUNT. `start` outside IDLE is ignored.
- RD_COUNT: `mem_address`=`count_addr`. Latch `cnt = min(mem_rdata, MAX_COUNT)`. Go to SCAN.
- SCAN: if `i`==`cnt`, the list is exhausted and no read is needed.
  - Exhausted with `append_en`=1 and `cnt`<`MAX_COUNT`: go to APPEND.
  - Exhausted with `cnt`==`MAX_COUNT` and `append_en`=1: `full`=1, go to DONE.
  - Exhausted with `append_en`=0: go to DONE with `found`=0 and `full`=0.
  - Otherwise `mem_address`=`list_base + 2*i`. If `mem_rdata`==`key`, set `found`=1, `index`=`i`, go to DONE; else `i`++.
- APPEND: `mem_address`=`list_base + 2*cnt`, `mem_wdata`=`key`, `mem_wr_en`=1, `index`=`cnt`. Go to INC_COUNT.
- INC_COUNT: `mem_address`=`count_addr`, `mem_wdata`=`cnt+1`, `mem_wr_en`=1. Go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^11 and wraps silently. `2*i` is a left shift.
- `mem_wr_en` is 0 in all states other than APPEND and INC_COUNT.
- `mem_address` is 0 and `mem_wdata` is 0 when idle.
- Duplicate entries: the lowest index wins.

## Timing
- Reset values: state IDLE; `busy`, `done`, `found`, `full`, `mem_wr_en` = 0; `index`, `mem_address`, `mem_wdata` = 0.
- Accepted `start` at edge E0:
  - RD_COUNT occupies cycle 1; SCAN i=0 occupies cycle 2.
  - Hit at index `i`: `done` in cycle 3+i.
  - Miss with append, count n: writes in cycles 3+n and 4+n; `done` in cycle 5+n.
  - Miss without append, or full: `done` in cycle 3+n.
- A write lands at the rising edge ending APPEND or INC_COUNT, so `mem` shows the new tail before INC_COUNT.
- Earliest back-to-back operation: `start` sampled in the cycle after DONE (IDLE).
- `reset` mid-operation: return to IDLE next edge. A write already issued at that edge completes. An append may therefore leave the key written without the count incremented; callers re-run the operation.

## Structure
- Shared package `lsa_pkg`: state enum, `ADDR_W`, `WORD_W`=16, `IDX_W`=6, standard list bases/count addresses (0x008/0x688, 0x668/0x68C, 0x248/0x68E).
- Single module; no sub-module is natural. The datapath is one comparator and one address adder.

## Test plan
- Bench memory: knownSinks at 0x008 = {2,5,10,171,205}, count at 0x688 = 5, `MAX_COUNT`=16.
- Hit: key=10, append_en=1 -> `done` 5 cycles after start, found=1, index=2, no write.
- Append: key=7 -> word 0x012 = 0x0007, 0x688 = 0x0006, found=0, index=5, `done` at cycle 10. Rerun key=7 -> found=1, index=5.
- Empty list: betterneighbors (0x668/0x68C, count 0), key=3 -> 0x668 = 0x0003, 0x68C = 1, `done` at cycle 5. With append_en=0 -> no write, `done` at cycle 3.
- Full: count word=16, key absent -> full=1, found=0, no `mem_wr_en`. Count word=40 is clamped to 16, same result.
- Control: `start` pulses while busy are ignored. `reset` asserted in SCAN -> outputs at reset values next cycle, memory unchanged. `reset` asserted in APPEND -> tail written, count unchanged.
